// File: rtl/ps2_scan_filter_fifo.sv
// ps2_scan_filter_fifo: folds PS/2 set-2 E0/F0 prefixes into tagged key events,
// optionally drops typematic repeats, and queues events in a show-ahead FIFO.
module ps2_scan_filter_fifo #(
    parameter int CODE_W          = 8,
    parameter int DEPTH           = 8,
    parameter int SUPPRESS_REPEAT = 1
) (
    input  logic                      Clk_F,
    input  logic                      Reset_F,
    input  logic [CODE_W-1:0]         ps2_Rx,
    input  logic                      rx_done,
    input  logic                      clear,
    output logic [CODE_W+1:0]         evt_data,
    output logic                      evt_valid,
    input  logic                      evt_ready,
    output logic [$clog2(DEPTH):0]    fifo_count,
    output logic                      overflow,
    output logic [CODE_W-1:0]         Save
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

    state_t              state_q, state_d;
    logic [CODE_W+1:0]   mem_q [DEPTH];
    logic [CODE_W+1:0]   mem_d [DEPTH];
    logic [AW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]         count_q, count_d;
    logic                ovf_q, ovf_d;
    logic [CODE_W-1:0]   save_q, save_d;
    logic                held_v_q, held_v_d;
    logic [CODE_W:0]     held_q, held_d;

    logic is_e0, is_f0, is_ctrl, key, ext, brk, hit, push_req, pop, full, do_push;
    logic [CODE_W+1:0] evt;

    always_comb begin
        is_e0    = ps2_Rx == CODE_W'(8'hE0);
        is_f0    = ps2_Rx == CODE_W'(8'hF0);
        is_ctrl  = ps2_Rx inside {CODE_W'(8'h00), CODE_W'(8'hAA), CODE_W'(8'hEE),
                                  CODE_W'(8'hFA), CODE_W'(8'hFE), CODE_W'(8'hFF)};
        ext      = state_q inside {EXT, EXT_BRK};
        brk      = state_q inside {BRK, EXT_BRK};
        evt      = {ext, brk, ps2_Rx};
        key      = rx_done & ~clear & ~is_ctrl & ~is_e0 & ~is_f0;
        hit      = held_v_q && (held_q == {ext, ps2_Rx});
        push_req = key & ~((SUPPRESS_REPEAT != 0) & ~brk & hit);
        pop      = (count_q != '0) & evt_ready;
        full     = count_q == (AW+1)'(DEPTH);
        // A pop in the same cycle frees the slot, so a full FIFO can still accept.
        do_push  = push_req & (~full | pop);
    end

    always_comb begin
        state_d = state_q;
        if (clear)
            state_d = IDLE;
        else if (rx_done)
            state_d = is_ctrl ? IDLE :
                      is_e0   ? EXT  :
                      !is_f0  ? IDLE :
                      (state_q == IDLE) ? BRK :
                      (state_q == EXT)  ? EXT_BRK : state_q;
    end

    always_comb begin
        held_d   = held_q;
        held_v_d = held_v_q;
        if (clear)
            held_v_d = 1'b0;
        else if (key && brk && hit)
            held_v_d = 1'b0;
        else if (key && !brk) begin
            held_d   = {ext, ps2_Rx};
            held_v_d = 1'b1;
        end
    end

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        save_d   = (do_push && !brk) ? ps2_Rx : save_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            ovf_d    = 1'b0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = evt;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (pop)
                rd_ptr_d = rd_ptr_q + 1'b1;
            count_d = count_q + (AW+1)'(do_push) - (AW+1)'(pop);
            ovf_d   = ovf_q | (push_req & full & ~pop);
        end
    end

    always_ff @(posedge Clk_F or negedge Reset_F) begin
        if (!Reset_F) begin
            state_q  <= IDLE;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            save_q   <= '0;
            held_v_q <= 1'b0;
            held_q   <= '0;
        end else begin
            state_q  <= state_d;
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            save_q   <= save_d;
            held_v_q <= held_v_d;
            held_q   <= held_d;
        end
    end

    assign evt_data   = mem_q[rd_ptr_q];
    assign evt_valid  = count_q != '0;
    assign fifo_count = count_q;
    assign overflow   = ovf_q;
    assign Save       = save_q;
endmodule

// File: tb/tb_ps2_scan_filter_fifo.sv
// tb_ps2_scan_filter_fifo: directed vectors with hand-computed expected events,
// run on a DEPTH=4 instance so the full/overflow boundary is reachable.
module tb_ps2_scan_filter_fifo;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] ps2_rx = '0;
    logic       rx_done = 1'b0;
    logic       clear = 1'b0;
    logic [9:0] evt_data;
    logic       evt_valid;
    logic       evt_ready = 1'b0;
    logic [2:0] fifo_count;
    logic       overflow;
    logic [7:0] save;
    int checks = 0;
    int errors = 0;

    ps2_scan_filter_fifo #(.CODE_W(8), .DEPTH(4), .SUPPRESS_REPEAT(1)) dut (
        .Clk_F(clk), .Reset_F(rst_n), .ps2_Rx(ps2_rx), .rx_done(rx_done), .clear(clear),
        .evt_data(evt_data), .evt_valid(evt_valid), .evt_ready(evt_ready),
        .fifo_count(fifo_count), .overflow(overflow), .Save(save)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        ps2_rx  = b;
        rx_done = 1'b1;
        @(posedge clk);
        #1 rx_done = 1'b0;
    endtask

    task automatic pop_chk(input string tag, input logic [9:0] exp);
        chk(tag, evt_data, exp);
        evt_ready = 1'b1;
        @(posedge clk);
        #1 evt_ready = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", evt_valid, 0);
        chk("rst_count", fifo_count, 0);
        chk("rst_data", evt_data, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_save", save, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("idle_valid", evt_valid, 0);

        send(8'h1C);
        chk("make_valid_lat", evt_valid, 1);
        chk("make_data", evt_data, 10'h01C);
        chk("make_save", save, 8'h1C);
        send(8'hF0);
        chk("prefix_no_evt", fifo_count, 1);
        send(8'h1C);
        chk("brk_count", fifo_count, 2);
        chk("brk_save", save, 8'h1C);
        pop_chk("head_make", 10'h01C);
        pop_chk("head_brk", 10'h11C);
        chk("drained", evt_valid, 0);

        send(8'hE0); send(8'h75);
        send(8'hE0); send(8'hF0); send(8'h75);
        chk("ext_count", fifo_count, 2);
        chk("ext_save", save, 8'h75);
        pop_chk("ext_make", 10'h275);
        pop_chk("ext_brk", 10'h375);

        send(8'h1C); send(8'h1C); send(8'h1C);
        send(8'hF0); send(8'h1C); send(8'h1C);
        chk("rep_count", fifo_count, 3);
        pop_chk("rep_0", 10'h01C);
        pop_chk("rep_1", 10'h11C);
        pop_chk("rep_2", 10'h01C);
        chk("rep_empty", fifo_count, 0);

        send(8'h15); send(8'h1D); send(8'h24); send(8'h2D); send(8'h2C);
        chk("full_count", fifo_count, 4);
        chk("full_ovf", overflow, 1);
        chk("full_head", evt_data, 10'h015);
        chk("full_save", save, 8'h2D);
        evt_ready = 1'b1;
        ps2_rx    = 8'h3C;
        rx_done   = 1'b1;
        @(posedge clk);
        #1 evt_ready = 1'b0;
        rx_done = 1'b0;
        chk("pp_count", fifo_count, 4);
        chk("pp_save", save, 8'h3C);
        pop_chk("pp_0", 10'h01D);
        pop_chk("pp_1", 10'h024);
        pop_chk("pp_2", 10'h02D);
        pop_chk("pp_last", 10'h03C);
        chk("pp_ovf_sticky", overflow, 1);
        evt_ready = 1'b1;
        @(posedge clk);
        #1 evt_ready = 1'b0;
        chk("pop_empty", fifo_count, 0);

        send(8'h4B); send(8'hE0);
        clear   = 1'b1;
        ps2_rx  = 8'h1C;
        rx_done = 1'b1;
        @(posedge clk);
        #1 clear = 1'b0;
        rx_done = 1'b0;
        chk("clr_count", fifo_count, 0);
        chk("clr_valid", evt_valid, 0);
        chk("clr_ovf", overflow, 0);
        chk("clr_save", save, 8'h4B);
        send(8'h33);
        chk("clr_idle", evt_data, 10'h033);
        pop_chk("clr_pop", 10'h033);

        send(8'hE0); send(8'hFA); send(8'h6B);
        chk("ctrl_drop", evt_data, 10'h06B);
        pop_chk("ctrl_pop", 10'h06B);

        send(8'hE0); send(8'hF0);
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        chk("rst_mid_save", save, 0);
        @(posedge clk);
        #1;
        send(8'h75);
        chk("rst_mid_count", fifo_count, 1);
        chk("rst_mid_data", evt_data, 10'h075);
        chk("rst_mid_save2", save, 8'h75);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
